// File: rtl/serial_parity_pkg.sv
// -----------------------------------------------------------------------------
// serial_parity_pkg
// Shared definitions for the serial parity receiver:
//   - DATA_W_DEFAULT : default number of data bits per frame
//   - rx_state_t     : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   - parity_mismatch: decides whether a received parity bit is wrong, given
//                      the XOR of the data bits and the parity sense
// -----------------------------------------------------------------------------
package serial_parity_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // acc is the XOR of all data bits. Under even parity the data plus the
  // parity bit must XOR to 0; under odd parity they must XOR to 1.
  function automatic logic parity_mismatch(input logic acc,
                                           input logic par_bit,
                                           input logic odd);
    logic w_sum;
    w_sum = acc ^ par_bit;
    return odd ? ~w_sum : w_sum;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// -----------------------------------------------------------------------------
// parity_accum
// One-bit XOR accumulator used to build the running parity of a frame.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears the accumulator
//   clr : synchronous clear (has priority over en)
//   en  : fold d into the accumulator on this edge
//   d   : bit to accumulate
//   acc : current accumulator value
// -----------------------------------------------------------------------------
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);

  logic r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 1'b0;
    end else if (clr) begin
      r_acc <= 1'b0;
    end else if (en) begin
      r_acc <= r_acc ^ d;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/serial_parity_rx.sv
// -----------------------------------------------------------------------------
// serial_parity_rx
// Serial frame receiver: start bit (0), DATA_W data bits LSB first, one parity
// bit, one stop bit (1). The line is sampled only on clk edges with bit_en=1.
// Frames with parity or stop-bit errors are still delivered, with the error
// flags set.
//
// Build option: define SERIAL_PARITY_ODD_EN for odd parity; without it the
// receiver expects even parity. Only the parity comparison changes.
//
// Parameters:
//   DATA_W     : data bits per frame (1..16)
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   bit_en     : bit-time strobe, rxd sampled when high
//   rxd        : serial line, idle high
//   dout       : last received data word (held until next valid)
//   valid      : one-cycle pulse after the stop bit is sampled
//   parity_err : parity mismatch on the frame flagged by valid
//   frame_err  : stop bit was 0 on the frame flagged by valid
//   busy       : FSM is not in IDLE
// -----------------------------------------------------------------------------
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rxd,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic ODD_PARITY = 1'b1;
`else
  localparam logic ODD_PARITY = 1'b0;
`endif

  localparam int              CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  rx_state_t         r_state;
  rx_state_t         w_state_next;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_dout;
  logic              r_par_mis;
  logic              r_valid;
  logic              r_parity_err;
  logic              r_frame_err;

  logic              w_start;
  logic              w_sample_data;
  logic              w_sample_par;
  logic              w_sample_stop;
  logic              w_acc;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and per-sample control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_sample_data = 1'b0;
    w_sample_par  = 1'b0;
    w_sample_stop = 1'b0;
    if (bit_en) begin
      case (r_state)
        IDLE: begin
          if (!rxd) begin
            w_start      = 1'b1;
            w_state_next = DATA;
          end
        end
        DATA: begin
          w_sample_data = 1'b1;
          if (r_count == LAST_IDX) begin
            w_state_next = PARITY;
          end
        end
        PARITY: begin
          w_sample_par = 1'b1;
          w_state_next = STOP;
        end
        STOP: begin
          w_sample_stop = 1'b1;
          w_state_next  = IDLE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Running parity of the data bits
  // ---------------------------------------------------------------------------
  parity_accum u_parity_accum (
    .clk (clk),
    .rst (rst),
    .clr (w_start),
    .en  (w_sample_data),
    .d   (rxd),
    .acc (w_acc)
  );

  // ---------------------------------------------------------------------------
  // Bit counter: cleared by the start bit, advanced by each data sample
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_start) begin
      r_count <= '0;
    end else if (w_sample_data) begin
      r_count <= r_count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Data assembly: each data sample lands in the bit addressed by the counter
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_shift[gi] <= 1'b0;
        end else if (w_sample_data && (r_count == CNT_W'(gi))) begin
          r_shift[gi] <= rxd;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Parity check result, held until the stop bit publishes it
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_mis <= 1'b0;
    end else if (w_sample_par) begin
      r_par_mis <= parity_mismatch(w_acc, rxd, ODD_PARITY);
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: everything updates on the stop-bit sample, so valid
  // is high during the following cycle and the payload holds until the next
  // frame completes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= w_sample_stop;
      if (w_sample_stop) begin
        r_dout       <= r_shift;
        r_parity_err <= r_par_mis;
        r_frame_err  <= ~rxd;
      end
    end
  end

  assign dout       = r_dout;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_rx
// Self-checking bench for serial_parity_rx (DATA_W=8). Frames are driven bit
// by bit with a configurable bit_en period; the expected result of each frame
// is computed from the frame contents and queued, and a monitor compares every
// valid pulse against the head of that queue.
// -----------------------------------------------------------------------------
module tb_serial_parity_rx;

  localparam int DW = 8;

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic ODD_EXP = 1'b1;
`else
  localparam logic ODD_EXP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          bit_en;
  logic          rxd;
  logic [DW-1:0] dout;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  serial_parity_rx #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .rxd        (rxd),
    .dout       (dout),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  exp_t          exp_q[$];
  int            vtimes[$];
  int            cyc;
  int            n_checks;
  int            n_errors;
  int            n_sent;
  logic [DW-1:0] last_d;
  logic          prev_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one line per delivered frame
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (valid) begin
        chk("valid_width", {31'd0, prev_valid}, 0);
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {31'd0, valid}, 0);
        end else begin
          e = exp_q.pop_front();
          $display("frame: dout=0x%02h perr=%0b ferr=%0b (exp 0x%02h %0b %0b)",
                   dout, parity_err, frame_err, e.d, e.pe, e.fe);
          chk("dout", {24'd0, dout}, {24'd0, e.d});
          chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
          last_d = e.d;
        end
        vtimes.push_back(cyc);
      end
      prev_valid = valid;
    end
  end

  // Present one bit; the strobe comes period cycles after the previous one.
  task automatic tick(input logic b, input int period);
    @(negedge clk);
    rxd    = b;
    bit_en = 1'b0;
    repeat (period - 1) @(negedge clk);
    bit_en = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pbit,
                            input logic sbit, input int period);
    exp_t e;
    e.d  = d;
    e.pe = (^d) ^ pbit ^ ODD_EXP;
    e.fe = ~sbit;
    exp_q.push_back(e);
    n_sent++;
    tick(1'b0, period);
    for (int i = 0; i < DW; i++) tick(d[i], period);
    tick(pbit, period);
    tick(sbit, period);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) tick(1'b1, 1);
    @(negedge clk);
    bit_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n0;
    logic [DW-1:0] rd;
    logic          rp;
    logic          rs;
    n_checks = 0;
    n_errors = 0;
    n_sent   = 0;
    cyc      = 0;
    last_d   = '0;
    rst      = 1'b1;
    bit_en   = 1'b0;
    rxd      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, dout}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_perr", {31'd0, parity_err}, 0);
    chk("rst_ferr", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;

    // Directed frames with bit_en held high
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    tick(1'b1, 1);
    tick(1'b1, 1);
    drain();

    // Back-to-back frames, bit_en every 4th cycle
    n0 = vtimes.size();
    tick(1'b1, 4);
    send_frame(8'h3C, 1'b0, 1'b1, 4);
    send_frame(8'hFF, 1'b0, 1'b1, 4);
    drain();
    if (vtimes.size() >= n0 + 2)
      chk("b2b_gap", vtimes[n0+1] - vtimes[n0], 44);
    else
      chk("b2b_count", vtimes.size(), n0 + 2);

    // Low glitch between strobes must not start a frame
    tick(1'b1, 4);
    @(negedge clk);
    bit_en = 1'b0;
    rxd    = 1'b0;
    @(negedge clk);
    rxd    = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 4);
    @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 0);

    // Reset in the middle of a frame: 0x5A cut after its 4th data bit
    tick(1'b0, 2);
    for (int i = 0; i < 4; i++) tick(rd_bit(8'h5A, i), 2);
    @(negedge clk);
    bit_en = 1'b0;
    chk("busy_midframe", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_valid", {31'd0, valid}, 0);
    chk("rst_mid_dout", {24'd0, dout}, 0);
    chk("rst_mid_perr", {31'd0, parity_err}, 0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_frame(8'h01, 1'b0, 1'b1, 2);
    drain();

    // Randomized frames: occasional bad parity or stop bit, varied strobe rate
    for (int k = 0; k < 24; k++) begin
      rd = DW'($urandom_range(0, 255));
      rp = (^rd) ^ ODD_EXP ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rd, rp, rs, int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) tick(1'b1, 1);
    end
    drain();
    repeat (4) @(negedge clk);

    chk("dout_hold", {24'd0, dout}, {24'd0, last_d});
    chk("pending_frames", exp_q.size(), 0);
    chk("valid_count", vtimes.size(), n_sent);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  function automatic logic rd_bit(input logic [DW-1:0] v, input int i);
    return v[i];
  endfunction

endmodule

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, setting the number of data bits per frame (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port bit_en, input, 1 bit: bit-time strobe; rxd is sampled only on clk edges where bit_en=1.
REQ-005 The block SHALL have port rxd, input, 1 bit: serial line; idle level is 1.
REQ-006 The block SHALL have port dout, output, DATA_W bits: last received data word.
REQ-007 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking a completed frame.
REQ-008 The block SHALL have port parity_err, output, 1 bit: parity mismatch on the frame flagged by valid.
REQ-009 The block SHALL have port frame_err, output, 1 bit: stop bit sampled as 0 on the frame flagged by valid.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 Frame format SHALL be: start bit (0), then DATA_W data bits LSB first, then one parity bit, then one stop bit (1).
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL advance only on bit_en=1 edges.
REQ-013 In IDLE, a sample of rxd=0 SHALL move the FSM to DATA and clear the bit counter and parity accumulator; a sample of rxd=1 SHALL leave it in IDLE.
REQ-014 In DATA, each sample SHALL be shifted into bit position count, XORed into the accumulator, and increment count; after sample DATA_W-1 the FSM SHALL move to PARITY.
REQ-015 In PARITY, the sample SHALL be XORed with the accumulator and the mismatch stored internally; the FSM SHALL then move to STOP.
REQ-016 In STOP, the sample SHALL be taken as the stop bit, and the FSM SHALL return to IDLE.
REQ-017 On the edge that samples the stop bit, dout, parity_err and frame_err SHALL update together, and valid SHALL be high for exactly the following clk cycle.
REQ-018 Frames containing errors SHALL still be delivered, with dout updated and the corresponding error flag set.
REQ-019 dout, parity_err and frame_err SHALL hold their values until the next valid pulse.
REQ-020 bit_en held high continuously SHALL be legal.
REQ-021 A start bit sampled on the first bit_en after STOP SHALL be accepted, so back-to-back frames are received with no idle gap.
REQ-022 A glitch low shorter than one bit_en period SHALL be ignored, because the line is sampled only on bit_en.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, count=0, accumulator=0, dout=0, valid=0, parity_err=0, frame_err=0 and busy=0, regardless of clk.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame and produce no valid pulse.
REQ-025 After rst deasserts, the first rxd=0 sample SHALL be treated as a start bit.

Configuration
REQ-026 With macro SERIAL_PARITY_ODD_EN defined, the block SHALL expect odd parity: the data bits plus the parity bit must contain an odd number of ones, otherwise parity_err=1.
REQ-027 Without SERIAL_PARITY_ODD_EN, the block SHALL expect even parity.
REQ-028 The macro SHALL affect only the parity comparison; FSM, timing and ports SHALL be identical in both builds.

Structure
REQ-029 Package serial_parity_pkg SHALL hold the state enum (IDLE, DATA, PARITY, STOP) and the constant DATA_W_DEFAULT=8.
REQ-030 Sub-module parity_accum SHALL hold the 1-bit XOR accumulator, with ports clk, rst, clr, en, d and acc; serial_parity_rx SHALL instantiate it once.
REQ-031 The counter width SHALL be $clog2(DATA_W)+1.

Verification
REQ-032 Even build, bit_en=1, frame 0 / 0xA5 LSB-first / parity 0 / stop 1 -> valid pulse with dout=0xA5, parity_err=0, frame_err=0.
REQ-033 Even build, 0xA5 with parity bit 1 -> dout=0xA5, parity_err=1, frame_err=0.
REQ-034 Frame 0x3C / parity 0 / stop 0 -> dout=0x3C, parity_err=0, frame_err=1.
REQ-035 Back-to-back frames 0x3C then 0xFF (parity 0), with bit_en every 4th cycle -> two valid pulses, 44 clk cycles apart, carrying dout 0x3C then 0xFF with no errors.
REQ-036 rst pulsed after the 4th data bit of 0x5A, then frame 0x01 sent -> no valid pulse for 0x5A, and busy=0 during reset; ODD build with 0x01 and parity 0 -> dout=0x01, parity_err=0.
